// File: rtl/tone_sequencer.sv
// tone_sequencer: edge-triggered, prioritised square-wave tone sequencer
// driving an N-bit DAC word. Priority BAD > GOOD > DIR; BAD is a two-note
// descending sweep (BAD1 then BAD2). A button edge toggles mute.
// Optional feature macro: SOUND_ENVELOPE_EN (decaying amplitude envelope).
module tone_sequencer #(
  parameter int unsigned    N         = 8,
  parameter int unsigned    DIV_W     = 16,
  parameter int unsigned    DUR_W     = 24,
  parameter logic [N-1:0]   AMP       = N'(8'hFF),
  parameter int unsigned    GOOD_HP   = 11364,
  parameter int unsigned    GOOD_DUR  = 1200000,
  parameter int unsigned    BAD_HP1   = 22727,
  parameter int unsigned    BAD_HP2   = 45455,
  parameter int unsigned    BAD_DUR   = 1800000,
  parameter int unsigned    DIR_HP    = 5682,
  parameter int unsigned    DIR_DUR   = 240000,
  parameter int unsigned    ENV_SHIFT = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         goodColl_i,
  input  logic         badColl_i,
  input  logic         button_i,
  input  logic [3:0]   direction_i,
  output logic [N-1:0] soundOut,
  output logic         busy,
  output logic         mode_o
);

  // Last count values; a zero half-period or duration behaves as 1.
  localparam logic [DIV_W-1:0] GOOD_HP_L  = DIV_W'(((GOOD_HP  == 0) ? 1 : GOOD_HP)  - 1);
  localparam logic [DIV_W-1:0] BAD_HP1_L  = DIV_W'(((BAD_HP1  == 0) ? 1 : BAD_HP1)  - 1);
  localparam logic [DIV_W-1:0] BAD_HP2_L  = DIV_W'(((BAD_HP2  == 0) ? 1 : BAD_HP2)  - 1);
  localparam logic [DIV_W-1:0] DIR_HP_L   = DIV_W'(((DIR_HP   == 0) ? 1 : DIR_HP)   - 1);
  localparam logic [DUR_W-1:0] GOOD_DUR_L = DUR_W'(((GOOD_DUR == 0) ? 1 : GOOD_DUR) - 1);
  localparam logic [DUR_W-1:0] BAD_DUR_L  = DUR_W'(((BAD_DUR  == 0) ? 1 : BAD_DUR)  - 1);
  localparam logic [DUR_W-1:0] DIR_DUR_L  = DUR_W'(((DIR_DUR  == 0) ? 1 : DIR_DUR)  - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GOOD = 3'd1,
    S_BAD1 = 3'd2,
    S_BAD2 = 3'd3,
    S_DIR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             good_q, bad_q, btn_q;
  logic [3:0]       dir_q;
  logic             mode_q, mode_d;
  logic             ev_good, ev_bad, ev_btn, ev_dir;
  logic [1:0]       ev_prio, cur_prio;
  state_t           ev_state;
  logic             restart, note_end;
  logic [DIV_W-1:0] hp_last;
  logic [DUR_W-1:0] dur_last;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             phase_q, phase_d;
  logic [N-1:0]     level;
  logic [N-1:0]     sound_d;
  logic             busy_d;

`ifdef SOUND_ENVELOPE_EN
  localparam logic [DUR_W-1:0] ENV_MASK = DUR_W'((64'd1 << ENV_SHIFT) - 64'd1);
  logic [N-1:0] amp_q, amp_d;
`endif

  assign ev_good  = goodColl_i & ~good_q;
  assign ev_bad   = badColl_i  & ~bad_q;
  assign ev_btn   = button_i   & ~btn_q;
  assign ev_dir   = (direction_i != dir_q) && (direction_i != 4'd0);
  assign mode_d   = mode_q ^ ev_btn;
  assign note_end = (state_q != S_IDLE) && (dur_q == dur_last);

  // Edge-detect history and mute mode; history tracks inputs even while muted.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_q <= 1'b0;
      bad_q  <= 1'b0;
      btn_q  <= 1'b0;
      dir_q  <= 4'd0;
      mode_q <= 1'b1;
    end else begin
      good_q <= goodColl_i;
      bad_q  <= badColl_i;
      btn_q  <= button_i;
      dir_q  <= direction_i;
      mode_q <= mode_d;
    end
  end

  // Current-note timing parameters selected by state.
  always_comb begin
    hp_last  = GOOD_HP_L;
    dur_last = GOOD_DUR_L;
    case (state_q)
      S_BAD1:  begin hp_last = BAD_HP1_L; dur_last = BAD_DUR_L; end
      S_BAD2:  begin hp_last = BAD_HP2_L; dur_last = BAD_DUR_L; end
      S_DIR:   begin hp_last = DIR_HP_L;  dur_last = DIR_DUR_L; end
      default: begin hp_last = GOOD_HP_L; dur_last = GOOD_DUR_L; end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: mute, note end / sweep continuation, then prioritised preemption.
  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    ev_prio  = 2'd0;
    ev_state = S_IDLE;
    cur_prio = 2'd0;
    if (ev_bad) begin
      ev_prio = 2'd3; ev_state = S_BAD1;
    end else if (ev_good) begin
      ev_prio = 2'd2; ev_state = S_GOOD;
    end else if (ev_dir) begin
      ev_prio = 2'd1; ev_state = S_DIR;
    end
    case (state_q)
      S_GOOD:         cur_prio = 2'd2;
      S_BAD1, S_BAD2: cur_prio = 2'd3;
      S_DIR:          cur_prio = 2'd1;
      default:        cur_prio = 2'd0;
    endcase
    // A note that ends this edge into IDLE leaves the channel free.
    if (note_end && (state_q != S_BAD1)) cur_prio = 2'd0;

    if (!mode_d) begin
      state_d = S_IDLE;
    end else begin
      if (note_end) begin
        if (state_q == S_BAD1) begin
          state_d = S_BAD2;
          restart = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      if ((ev_prio != 2'd0) && (ev_prio >= cur_prio)) begin
        state_d = ev_state;
        restart = 1'b1;
      end
    end
  end

  // Next counter, phase, amplitude and output values for the next state.
  always_comb begin
    div_d   = '0;
    dur_d   = '0;
    phase_d = 1'b0;
    sound_d = '0;
    busy_d  = 1'b0;
`ifdef SOUND_ENVELOPE_EN
    amp_d   = amp_q;
`endif
    if (state_d != S_IDLE) begin
      busy_d = 1'b1;
      if (restart) begin
        phase_d = 1'b1;
`ifdef SOUND_ENVELOPE_EN
        amp_d   = AMP;
`endif
      end else begin
        dur_d = dur_q + DUR_W'(1);
        if (div_q == hp_last) begin
          div_d   = '0;
          phase_d = ~phase_q;
        end else begin
          div_d   = div_q + DIV_W'(1);
          phase_d = phase_q;
        end
`ifdef SOUND_ENVELOPE_EN
        if (((dur_q & ENV_MASK) == ENV_MASK) && (amp_q != '0)) amp_d = amp_q - N'(1);
`endif
      end
      sound_d = phase_d ? level : '0;
    end
  end

`ifdef SOUND_ENVELOPE_EN
  assign level = amp_d;
`else
  assign level = AMP;
`endif

  // Datapath counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      dur_q    <= '0;
      phase_q  <= 1'b0;
      soundOut <= '0;
      busy     <= 1'b0;
    end else begin
      div_q    <= div_d;
      dur_q    <= dur_d;
      phase_q  <= phase_d;
      soundOut <= sound_d;
      busy     <= busy_d;
    end
  end

`ifdef SOUND_ENVELOPE_EN
  // Envelope amplitude register.
  always_ff @(posedge clk) begin
    if (rst) amp_q <= '0;
    else     amp_q <= amp_d;
  end
`endif

  assign mode_o = mode_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized + directed bench for tone_sequencer against a timeline model:
// each tone is tracked as (kind, start cycle) and outputs are derived from
// elapsed cycles with plain arithmetic.
module tb_tone_sequencer;

  localparam int unsigned N         = 8;
  localparam logic [7:0]  AMP       = 8'hFF;
  localparam int unsigned GOOD_HP   = 4;
  localparam int unsigned GOOD_DUR  = 20;
  localparam int unsigned BAD_HP1   = 2;
  localparam int unsigned BAD_HP2   = 3;
  localparam int unsigned BAD_DUR   = 12;
  localparam int unsigned DIR_HP    = 1;
  localparam int unsigned DIR_DUR   = 6;
  localparam int unsigned ENV_SHIFT = 2;

  // Tone kinds in the model: 0 none, 1 dir, 2 good, 3 bad note 1, 4 bad note 2.
  localparam int K_NONE = 0, K_DIR = 1, K_GOOD = 2, K_BAD1 = 3, K_BAD2 = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         good, bad, btn;
  logic [3:0]   dir;
  logic [N-1:0] sound_out;
  logic         busy;
  logic         mode;

  int vectors     = 0;
  int miscompares = 0;
  int t           = 0;

  int       m_kind;
  int       m_start;
  bit       m_mode;
  bit       p_good, p_bad, p_btn;
  bit [3:0] p_dir;

  tone_sequencer #(
    .N(N), .AMP(AMP),
    .GOOD_HP(GOOD_HP), .GOOD_DUR(GOOD_DUR),
    .BAD_HP1(BAD_HP1), .BAD_HP2(BAD_HP2), .BAD_DUR(BAD_DUR),
    .DIR_HP(DIR_HP), .DIR_DUR(DIR_DUR), .ENV_SHIFT(ENV_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .goodColl_i(good), .badColl_i(bad), .button_i(btn), .direction_i(dir),
    .soundOut(sound_out), .busy(busy), .mode_o(mode)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  function automatic int hp_of(input int k);
    case (k)
      K_DIR:   return DIR_HP;
      K_GOOD:  return GOOD_HP;
      K_BAD1:  return BAD_HP1;
      default: return BAD_HP2;
    endcase
  endfunction

  function automatic int dur_of(input int k);
    case (k)
      K_DIR:   return DIR_DUR;
      K_GOOD:  return GOOD_DUR;
      default: return BAD_DUR;
    endcase
  endfunction

  function automatic int prio_of(input int k);
    case (k)
      K_DIR:        return 1;
      K_GOOD:       return 2;
      K_BAD1, K_BAD2: return 3;
      default:      return 0;
    endcase
  endfunction

  function automatic int level_at(input int j);
`ifdef SOUND_ENVELOPE_EN
    int a;
    a = int'(AMP) - (j >> ENV_SHIFT);
    return (a < 0) ? 0 : a;
`else
    return int'(AMP);
`endif
  endfunction

  // Advance the model by one clock edge using the inputs just sampled.
  task automatic model_step();
    bit e_good, e_bad, e_btn, e_dir;
    int ep;
    if (rst) begin
      m_kind = K_NONE; m_mode = 1'b1;
      p_good = 0; p_bad = 0; p_btn = 0; p_dir = 4'd0;
      return;
    end
    e_good = good && !p_good;
    e_bad  = bad && !p_bad;
    e_btn  = btn && !p_btn;
    e_dir  = (dir != p_dir) && (dir != 4'd0);
    p_good = good; p_bad = bad; p_btn = btn; p_dir = dir;
    if (e_btn) m_mode = !m_mode;
    if (m_kind != K_NONE && (t - m_start) == dur_of(m_kind)) begin
      if (m_kind == K_BAD1) begin
        m_kind = K_BAD2; m_start = t;
      end else begin
        m_kind = K_NONE;
      end
    end
    if (!m_mode) begin
      m_kind = K_NONE;
    end else begin
      ep = e_bad ? 3 : e_good ? 2 : e_dir ? 1 : 0;
      if (ep > 0 && ep >= prio_of(m_kind)) begin
        m_kind  = (ep == 3) ? K_BAD1 : (ep == 2) ? K_GOOD : K_DIR;
        m_start = t;
      end
    end
  endtask

  // One clock: inputs already applied; sample #1 after the edge and compare.
  task automatic cycle();
    int j, exp_s, exp_b;
    @(posedge clk);
    #1;
    t++;
    model_step();
    if (m_kind == K_NONE) begin
      exp_s = 0; exp_b = 0;
    end else begin
      j = t - m_start;
      exp_s = (((j / hp_of(m_kind)) % 2) == 0) ? level_at(j) : 0;
      exp_b = 1;
    end
    check_eq("soundOut", 32'(sound_out), 32'(exp_s));
    check_eq("busy", 32'(busy), 32'(exp_b));
    check_eq("mode_o", 32'(mode), 32'(m_mode));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; good = 1'b0; bad = 1'b0; btn = 1'b0; dir = 4'd0;
    m_kind = K_NONE; m_start = 0; m_mode = 1'b1;
    p_good = 0; p_bad = 0; p_btn = 0; p_dir = 4'd0;
    @(negedge clk);
    run(3);
    rst = 1'b0;
    run(2);

    // Single good tone, then bad sweep.
    good = 1'b1; cycle(); good = 1'b0; run(24);
    bad  = 1'b1; cycle(); bad  = 1'b0; run(28);

    // Direction during GOOD is dropped; bad during GOOD preempts.
    good = 1'b1; cycle(); good = 1'b0; run(5);
    dir = 4'b0001; run(17);
    good = 1'b1; cycle(); good = 1'b0; run(7);
    bad = 1'b1; cycle(); bad = 1'b0; run(28);

    // Simultaneous good and bad.
    good = 1'b1; bad = 1'b1; cycle(); good = 1'b0; bad = 1'b0; run(28);

    // Mute mid-tone, event while muted, unmute and play.
    good = 1'b1; cycle(); good = 1'b0; run(6);
    btn = 1'b1; cycle(); btn = 1'b0; run(3);
    good = 1'b1; cycle(); good = 1'b0; run(22);
    btn = 1'b1; cycle(); btn = 1'b0; run(2);
    good = 1'b1; cycle(); good = 1'b0; run(22);

    // Held level and direction patterns.
    good = 1'b1; run(50); good = 1'b0; run(3);
    dir = 4'b0000; run(3); dir = 4'b0001; run(8);
    dir = 4'b0010; run(8);

    // Reset mid-tone.
    bad = 1'b1; cycle(); bad = 1'b0; run(5);
    rst = 1'b1; cycle(); rst = 1'b0; run(3);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) good = ~good;
      if ($urandom_range(0, 39) == 0) bad  = ~bad;
      btn = ($urandom_range(0, 149) == 0) ? ~btn : btn;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 4))
          0: dir = 4'b0000;
          1: dir = 4'b0001;
          2: dir = 4'b0010;
          3: dir = 4'b0100;
          default: dir = 4'b1000;
        endcase
      end
      rst = ($urandom_range(0, 799) == 0);
      cycle();
    end
    rst = 1'b0;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
